ft_lockstep_voter: RTL and testbench
====================================

# ft_lockstep_voter

Parametrised successor to the fault-tolerance module's write-back comparator. It compares the register-file write ports of 2 (DMR) or 3 (TMR) lockstep cores every cycle. In TMR mode it forwards the majority value; in DMR mode it detects mismatches. It registers the result, counts errors, tracks persistent per-core faults and runs a recovery request/acknowledge handshake with the recovery controller.

## Interface
- NUM_CORES, 3, number of lockstep cores; legal values 2 (DMR) and 3 (TMR).
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, write-back data width.
- CNT_WIDTH, 8, width of the saturating error counter.
- FAULT_THRESH, 4, consecutive faulty checks of one core that trigger recovery (TMR only); ≥1.

- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  NUM_CORES  per-core valid write-back instruction.
- we_i  in  NUM_CORES  per-core register write enable.
- addr_i  in  NUM_CORES*ADDR_WIDTH  packed per-core addresses; core k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- data_i  in  NUM_CORES*DATA_WIDTH  packed per-core data; same packing.
- clear_i  in  1  clears err_count_o.
- recover_ack_i  in  1  recovery controller acknowledge.
- valid_o, we_o  out  1  voted valid / write enable.
- addr_o  out  ADDR_WIDTH  voted address.
- data_o  out  DATA_WIDTH  voted data.
- error_o  out  1  one-cycle pulse: the check found any mismatch.
- uncorrectable_o  out  1  one-cycle pulse: no majority exists.
- faulty_o  out  NUM_CORES  one-cycle mask of cores that disagree with the majority.
- err_count_o  out  CNT_WIDTH  saturating count of checks with error.
- recover_req_o  out  1  recovery request; level signal.
- recover_core_o  out  NUM_CORES  cores to be recovered; held while recover_req_o=1.

## Operation
- Tuple t_k = {valid_i[k], we_i[k], addr_k, data_k}. A check happens in a cycle where the FSM is RUN and any valid_i bit is 1. Otherwise no check: valid_o=we_o=0, error/faulty/uncorrectable pulses 0.
- TMR vote: if t0==t1 or t0==t2, the winner is t0; else if t1==t2, the winner is t1; else uncorrectable. faulty_o[k]=1 for each core whose t_k differs from the winner.
- DMR: t0!=t1 is uncorrectable. faulty_o=0.
- With a winner: outputs take the winner's fields.
- Uncorrectable: valid_o=we_o=0. addr_o/data_o hold their previous values.
- error_o = any mismatch. err_count_o increments by 1 per check with error and saturates at 2^CNT_WIDTH-1. clear_i sets it to 0; clear_i wins over a simultaneous increment.
- Per-core streak counter: on a check, increment if faulty_o[k], else reset to 0. Not changed in non-check cycles.
- FSM RUN→RECOVER on either trigger:
  - an uncorrectable check: recover_core_o = all ones;
  - any streak reaching FAULT_THRESH: recover_core_o = the cores that reached it.
- RECOVER:
  - recover_req_o=1; inputs are ignored (no checks, counter and streaks frozen, valid_o=we_o=0);
  - on recover_ack_i=1 the FSM goes to RUN at the next edge; recover_req_o and recover_core_o go to 0 and all streaks clear.
- recover_ack_i in RUN is ignored. clear_i is honoured in both states.
- Reset values: state RUN; valid_o, we_o, addr_o, data_o, error_o, uncorrectable_o, faulty_o, err_count_o, recover_req_o, recover_core_o all 0; streaks 0.

## Timing
- Latency 1 cycle: inputs sampled at edge n drive all outputs from edge n until edge n+1.
- The triggering check's outputs (error_o, faulty_o/uncorrectable_o, incremented count) and recover_req_o=1 rise on the same edge.
- The first check after recovery uses inputs sampled on the edge where recover_req_o falls; its results appear one cycle later.
- Minimum RECOVER duration is 1 cycle: ack already high at entry exits at the next edge.
- rst_i in any state, including mid-RECOVER: all state returns to reset values at that edge and overrides every other input.

## Test plan
- TMR, all cores equal {1,1,5'd3,32'hDEADBEEF} → next cycle valid_o=1, addr_o=3, data_o=DEADBEEF, error_o=0, count 0.
- TMR, core 1 data=32'h0 for one cycle → data_o=DEADBEEF, error_o=1, faulty_o=3'b010, count 1, recover_req_o=0.
- TMR, core 2 wrong for 4 consecutive checks (FAULT_THRESH=4), idle cycles interleaved → recover_req_o rises with the 4th error, recover_core_o=3'b100; ack after 3 cycles → RUN, streaks 0.
- TMR, all three data differ → valid_o=0, uncorrectable_o=1, recover_core_o=3'b111, addr_o/data_o unchanged.
- DMR, valid_i=2'b01 → uncorrectable, recover request; clear_i together with a later error → err_count_o=0.
- CNT_WIDTH=2, 5 error checks → count saturates at 3; rst_i asserted in RECOVER → all outputs 0 next cycle.

Source files
------------

// File: rtl/ft_lockstep_voter.sv
// ft_lockstep_voter: DMR/TMR write-back comparator with majority vote, error
// counting, per-core fault streaks and a recovery request/acknowledge handshake.
module ft_lockstep_voter #(
  parameter int NUM_CORES    = 3,
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 8,
  parameter int FAULT_THRESH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_CORES-1:0]             valid_i,
  input  logic [NUM_CORES-1:0]             we_i,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  data_i,
  input  logic                             clear_i,
  input  logic                             recover_ack_i,
  output logic                             valid_o,
  output logic                             we_o,
  output logic [ADDR_WIDTH-1:0]            addr_o,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             error_o,
  output logic                             uncorrectable_o,
  output logic [NUM_CORES-1:0]             faulty_o,
  output logic [CNT_WIDTH-1:0]             err_count_o,
  output logic                             recover_req_o,
  output logic [NUM_CORES-1:0]             recover_core_o
);
  localparam int TW = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam int SW = $clog2(FAULT_THRESH + 1);
  typedef enum logic {RUN, RECOVER} state_t;
  state_t               r_state;
  logic [SW-1:0]        r_streak [NUM_CORES];
  logic [TW-1:0]        w_t [NUM_CORES];
  logic [TW-1:0]        w_win;
  logic                 w_unc;
  logic                 w_check;
  logic                 w_err;
  logic                 w_good;
  logic [NUM_CORES-1:0] w_faulty;
  logic [NUM_CORES-1:0] w_hit;
  genvar k;
  for (k = 0; k < NUM_CORES; k++) begin : g_tuple
    assign w_t[k]   = {valid_i[k], we_i[k], addr_i[k*ADDR_WIDTH +: ADDR_WIDTH], data_i[k*DATA_WIDTH +: DATA_WIDTH]};
    assign w_hit[k] = w_faulty[k] && r_streak[k] == SW'(FAULT_THRESH - 1);
  end
  assign w_check = r_state == RUN && |valid_i;
  if (NUM_CORES == 3) begin : g_tmr
    logic w_e01, w_e02, w_e12;
    assign w_e01 = w_t[0] == w_t[1];
    assign w_e02 = w_t[0] == w_t[2];
    assign w_e12 = w_t[1] == w_t[2];
    assign w_win = (w_e01 || w_e02) ? w_t[0] : w_t[1];
    assign w_unc = !(w_e01 || w_e02 || w_e12);
    for (k = 0; k < 3; k++) begin : g_flt
      assign w_faulty[k] = w_check && !w_unc && w_t[k] != w_win;
    end
  end else begin : g_dmr
    assign w_win    = w_t[0];
    assign w_unc    = w_t[0] != w_t[1];
    assign w_faulty = '0;
  end
  assign w_good = w_check && !w_unc;
  assign w_err  = w_check && (w_unc || |w_faulty);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= RUN;
      valid_o         <= 1'b0;
      we_o            <= 1'b0;
      addr_o          <= '0;
      data_o          <= '0;
      error_o         <= 1'b0;
      uncorrectable_o <= 1'b0;
      faulty_o        <= '0;
      err_count_o     <= '0;
      recover_req_o   <= 1'b0;
      recover_core_o  <= '0;
      for (int i = 0; i < NUM_CORES; i++) r_streak[i] <= '0;
    end else begin
      valid_o         <= w_good && w_win[TW-1];
      we_o            <= w_good && w_win[TW-2];
      error_o         <= w_err;
      uncorrectable_o <= w_check && w_unc;
      faulty_o        <= w_faulty;
      err_count_o     <= clear_i ? '0 : (w_err && ~&err_count_o) ? err_count_o + CNT_WIDTH'(1) : err_count_o;
      if (w_good) begin
        addr_o <= w_win[DATA_WIDTH +: ADDR_WIDTH];
        data_o <= w_win[DATA_WIDTH-1:0];
      end
      for (int i = 0; i < NUM_CORES; i++)
        r_streak[i] <= (r_state == RECOVER && recover_ack_i) ? '0 : w_check ? (w_faulty[i] ? r_streak[i] + SW'(1) : '0) : r_streak[i];
      if (w_check && (w_unc || |w_hit)) begin
        r_state        <= RECOVER;
        recover_req_o  <= 1'b1;
        recover_core_o <= w_unc ? '1 : w_hit;
      end else if (r_state == RECOVER && recover_ack_i) begin
        r_state        <= RUN;
        recover_req_o  <= 1'b0;
        recover_core_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ft_lockstep_voter.sv
// tb_ft_lockstep_voter: scoreboard bench driving a TMR instance and a DMR
// instance (2-bit counter) with directed and random write-back tuples.
module tb_ft_lockstep_voter;
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
    logic        unc;
    logic [2:0]  faulty;
    logic [7:0]  cnt;
    logic        req;
    logic [2:0]  core;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic [2:0]  tv [2];
  logic [2:0]  twe [2];
  logic [4:0]  ta [2][3];
  logic [31:0] td [2][3];
  logic        tclr [2];
  logic        tack [2];
  logic        v0, we0, e0, u0, r0, v1, we1, e1, u1, r1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic [2:0]  f0, c0;
  logic [1:0]  f1, c1, n1;
  logic [7:0]  n0;
  exp_t        act [2];
  exp_t        q [2][$];
  exp_t        me;
  logic        m_run [2];
  int          m_cnt [2];
  int          m_str [2][3];
  logic        m_req [2];
  logic [2:0]  m_core [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  ft_lockstep_voter dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(tv[0]), .we_i(twe[0]),
    .addr_i({ta[0][2], ta[0][1], ta[0][0]}), .data_i({td[0][2], td[0][1], td[0][0]}),
    .clear_i(tclr[0]), .recover_ack_i(tack[0]),
    .valid_o(v0), .we_o(we0), .addr_o(a0), .data_o(d0), .error_o(e0), .uncorrectable_o(u0),
    .faulty_o(f0), .err_count_o(n0), .recover_req_o(r0), .recover_core_o(c0));
  ft_lockstep_voter #(.NUM_CORES(2), .CNT_WIDTH(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(tv[1][1:0]), .we_i(twe[1][1:0]),
    .addr_i({ta[1][1], ta[1][0]}), .data_i({td[1][1], td[1][0]}),
    .clear_i(tclr[1]), .recover_ack_i(tack[1]),
    .valid_o(v1), .we_o(we1), .addr_o(a1), .data_o(d1), .error_o(e1), .uncorrectable_o(u1),
    .faulty_o(f1), .err_count_o(n1), .recover_req_o(r1), .recover_core_o(c1));
  assign act[0] = {v0, we0, a0, d0, e0, u0, f0, n0, r0, c0};
  assign act[1] = {v1, we1, a1, d1, e1, u1, 1'b0, f1, 6'b0, n1, r1, 1'b0, c1};
  // Reference: a check's winner is any tuple held by a strict majority of cores.
  task automatic model(int d);
    int nc = (d == 0) ? 3 : 2;
    int cmax = (d == 0) ? 255 : 3;
    logic [38:0] t [3];
    int w = -1;
    bit chk = 0;
    logic [2:0] hit = '0;
    exp_t e = '0;
    for (int k = 0; k < nc; k++) begin
      t[k] = {tv[d][k], twe[d][k], ta[d][k], td[d][k]};
      chk |= tv[d][k];
    end
    if (rst) begin
      m_run[d] = 1; m_cnt[d] = 0; m_req[d] = 0; m_core[d] = 0; m_addr[d] = 0; m_data[d] = 0;
      for (int k = 0; k < 3; k++) m_str[d][k] = 0;
      q[d].push_back(e);
      return;
    end
    chk = chk && m_run[d];
    e.addr = m_addr[d];
    e.data = m_data[d];
    if (chk) begin
      for (int i = 0; i < nc; i++) begin
        int n = 0;
        for (int j = 0; j < nc; j++) if (t[j] == t[i]) n++;
        if (w < 0 && 2 * n > nc) w = i;
      end
      if (w >= 0) begin
        {e.valid, e.we, e.addr, e.data} = t[w];
        for (int k = 0; k < nc; k++) if (nc == 3 && t[k] != t[w]) e.faulty[k] = 1;
        e.err = |e.faulty;
      end else begin
        e.unc = 1;
        e.err = 1;
      end
      m_addr[d] = e.addr;
      m_data[d] = e.data;
      for (int k = 0; k < nc; k++) begin
        m_str[d][k] = e.faulty[k] ? m_str[d][k] + 1 : 0;
        if (m_str[d][k] == 4) hit[k] = 1;
      end
    end
    if (tclr[d]) m_cnt[d] = 0;
    else if (e.err && m_cnt[d] < cmax) m_cnt[d]++;
    if (chk && (e.unc || |hit)) begin
      m_run[d] = 0; m_req[d] = 1;
      m_core[d] = e.unc ? ((nc == 3) ? 3'b111 : 3'b011) : hit;
    end else if (!m_run[d] && tack[d]) begin
      m_run[d] = 1; m_req[d] = 0; m_core[d] = 0;
      for (int k = 0; k < 3; k++) m_str[d][k] = 0;
    end
    e.cnt = 8'(m_cnt[d]);
    e.req = m_req[d];
    e.core = m_core[d];
    q[d].push_back(e);
  endtask
  task automatic step();
    model(0);
    model(1);
    @(negedge clk);
  endtask
  task automatic set_all(int d, logic v, logic we, logic [4:0] a, logic [31:0] dt);
    for (int k = 0; k < 3; k++) begin
      tv[d][k] = v; twe[d][k] = we; ta[d][k] = a; td[d][k] = dt;
    end
  endtask
  task automatic rnd(int d);
    set_all(d, $urandom_range(0, 9) != 0, 1'($urandom), 5'($urandom), $urandom);
    for (int k = 0; k < 3; k++)
      if ($urandom_range(0, 3) == 0)
        case ($urandom_range(0, 3))
          0: tv[d][k] = ~tv[d][k];
          1: twe[d][k] = ~twe[d][k];
          2: ta[d][k] = ta[d][k] ^ 5'($urandom_range(1, 31));
          default: td[d][k] = td[d][k] ^ (32'h1 << $urandom_range(0, 31));
        endcase
    if ($urandom_range(0, 5) == 0) tv[d] = '0;
    tclr[d] = $urandom_range(0, 15) == 0;
    tack[d] = $urandom_range(0, 2) == 0;
  endtask
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      if (q[d].size() > 0) begin
        me = q[d].pop_front();
        checks++;
        if (act[d] !== me) begin
          errors++;
          $display("FAIL dut%0d outputs at %0t: got %h required %h", d, $time, act[d], me);
        end
      end
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      set_all(d, 0, 0, 0, 0);
      tclr[d] = 0;
      tack[d] = 0;
    end
    @(negedge clk);
    step();
    step();
    rst = 0;
    set_all(0, 1, 1, 5'd3, 32'hDEADBEEF);
    step();
    td[0][1] = 32'h0;
    step();
    td[0][1] = 32'hDEADBEEF;
    for (int n = 0; n < 4; n++) begin
      td[0][2] = 32'h1234 + n;
      step();
      tv[0] = '0;
      step();
      tv[0] = 3'b111;
    end
    td[0][2] = 32'hDEADBEEF;
    for (int n = 0; n < 3; n++) step();
    tack[0] = 1;
    step();
    tack[0] = 0;
    step();
    td[0][1] = 32'h1;
    td[0][2] = 32'h2;
    step();
    step();
    tack[0] = 1;
    set_all(0, 1, 1, 5'd3, 32'hDEADBEEF);
    step();
    tack[0] = 0;
    step();
    set_all(1, 0, 1, 5'd7, 32'hCAFE0000);
    tv[1][0] = 1;
    step();
    step();
    tack[1] = 1;
    step();
    tack[1] = 0;
    tclr[1] = 1;
    step();
    tclr[1] = 0;
    tack[1] = 1;
    for (int n = 0; n < 10; n++) step();
    tack[1] = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    for (int n = 0; n < 600; n++) begin
      rnd(0);
      rnd(1);
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0;
    set_all(0, 0, 0, 0, 0);
    set_all(1, 0, 0, 0, 0);
    step();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q[0].size() + q[1].size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending required 0", q[0].size() + q[1].size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
